// File: rtl/dma_rd_port_pkg.sv
// rtl/dma_rd_port_pkg.sv - shared defaults and sizing helper for the DMA read port
package dma_rd_port_pkg;

   localparam int DEF_AW    = 11;
   localparam int DEF_IFW   = 8;
   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 4;

   // Occupancy counters must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dma_rd_port_sync_fifo.sv
// rtl/dma_rd_port_sync_fifo.sv - power-of-two synchronous FIFO with occupancy count
module dma_rd_port_sync_fifo
   import dma_rd_port_pkg::*;
#(
   parameter int W     = DEF_DW + DEF_IFW + 2,
   parameter int DEPTH = DEF_DEPTH,
   localparam int CW   = cnt_w(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          empty
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop_ok;

   assign empty  = (count == '0);
   assign pop_ok = pop && !empty;
   assign head   = mem[rd_ptr];

   // Storage is deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PW'(wr_ptr + 1'b1);
         end
         if (pop_ok) begin
            rd_ptr <= PW'(rd_ptr + 1'b1);
         end
         case ({push, pop_ok})
            2'b10:   count <= CW'(count + 1'b1);
            2'b01:   count <= CW'(count - 1'b1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dma_rd_port.sv
// rtl/dma_rd_port.sv - credit-controlled SRAM read responder for the DMA address stream
module dma_rd_port
   import dma_rd_port_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int IFW   = DEF_IFW,
   parameter int DW    = DEF_DW,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [AW-1:0]  in_addr,
   input  logic [IFW-1:0] in_info,
   input  logic           in_first,
   input  logic           in_last,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           mem_en,
   output logic [AW-1:0]  mem_addr,
   input  logic [DW-1:0]  mem_rdata,
   output logic [DW-1:0]  m_data,
   output logic [IFW-1:0] m_info,
   output logic           m_first,
   output logic           m_last,
   output logic           m_valid,
   input  logic           m_ready,
   output logic           busy
);

   localparam int W  = DW + IFW + 2;
   localparam int CW = cnt_w(DEPTH);

   logic           issue;
   logic           inflight;
   logic [IFW-1:0] p_info;
   logic           p_first;
   logic           p_last;
   logic [CW:0]    credit_used;
   logic [CW-1:0]  fifo_count;
   logic           fifo_empty;
   logic [W-1:0]   fifo_head;
   logic           pop;

   // Credits come from registers only, so in_ready never depends on m_ready or in_valid.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign in_ready    = (credit_used < (CW+1)'(DEPTH));

   assign issue    = in_valid && in_ready;
   assign mem_en   = issue;
   assign mem_addr = in_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 1'b0;
         p_info   <= '0;
         p_first  <= 1'b0;
         p_last   <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            p_info  <= in_info;
            p_first <= in_first;
            p_last  <= in_last;
         end
      end
   end

   assign pop = m_valid && m_ready;

   dma_rd_port_sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data ({mem_rdata, p_info, p_first, p_last}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign {m_data, m_info, m_first, m_last} = fifo_head;
   assign m_valid = !fifo_empty;
   assign busy    = inflight || !fifo_empty;

endmodule
